// File: rtl/loader_pkg.sv
// Shared opcode constants, loader state encoding and the opcode legality test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd14;
  localparam logic [3:0] OP_JMP = 4'd15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    WR   = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_LW, OP_SW, OP_BNE, OP_JMP: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_checker.sv
// Flags an instruction word with an illegal opcode or a branch/jump target outside 0..N.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the loader presents a word.
// Ports: word_i (instruction), addr_i (its word address t), n_i (program length),
//        illegal_o (opcode not legal), out_of_range_o (bne/jmp target < 0 or > N).
module instr_checker
  import loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] n_i,
  output logic              illegal_o,
  output logic              out_of_range_o
);

  // Six extra bits hold the 12-bit jmp offset plus sign without overflow.
  localparam int TW = ADDR_W + 6;

  logic [TW-1:0] offset;
  logic [TW-1:0] target;
  logic          is_branch;

  always_comb begin
    offset = '0;
    case (word_i[3:0])
      OP_BNE:  offset = {{(TW-4){word_i[15]}}, word_i[15:12]};
      OP_JMP:  offset = {{(TW-12){word_i[15]}}, word_i[15:4]};
      default: offset = '0;
    endcase
  end

  assign target    = {6'b0, addr_i} + offset;
  assign is_branch = (word_i[3:0] == OP_BNE) || (word_i[3:0] == OP_JMP);

  // MSB set means negative; otherwise an unsigned compare against N is exact.
  assign out_of_range_o = is_branch && (target[TW-1] || (target > {6'b0, n_i}));
  assign illegal_o      = !is_legal_op(word_i[3:0]);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory as 16-bit words.
// Latency: each word is written the cycle after its high byte; full load = 1 + 3N + 1 cycles.
// Backpressure: in_ready high only in LEN/LO/HI/CHK; a byte moves when in_valid & in_ready.
// Ports: clock/reset_n; start; in_valid/in_data/in_ready byte stream; imem_we/addr/wdata
//        write port; prog_len, busy, done, err_len, err_chk, err_target, bad_count status.
module program_loader
  import loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 101,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] prog_len,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              err_chk,
  output logic              err_target,
  output logic [ADDR_W-1:0] bad_count
);

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, cnt_q, cnt_inc;
  logic [7:0]        lo_q, hi_q, acc_q;
  logic [ADDR_W-1:0] prog_len_q, bad_q;
  logic              err_len_q, err_chk_q, err_target_q;
  logic              xfer, len_bad, start_ok;
  logic              illegal, out_of_range;

  assign xfer     = in_valid && in_ready;
  assign len_bad  = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_L);
  assign cnt_inc  = cnt_q + 1'b1;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  instr_checker #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_chk (
    .word_i         ({hi_q, lo_q}),
    .addr_i         (cnt_q),
    .n_i            (n_q),
    .illegal_o      (illegal),
    .out_of_range_o (out_of_range)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)  state_d = LEN;
      LEN:        if (xfer)   state_d = len_bad ? DONE : LO;
      LO:         if (xfer)   state_d = HI;
      HI:         if (xfer)   state_d = WR;
      WR:                     state_d = (cnt_inc == n_q) ? CHK : LO;
      CHK:        if (xfer)   state_d = DONE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs; write address/data are held at zero outside the write cycle.
  always_comb begin
    in_ready   = (state_q == LEN) || (state_q == LO) || (state_q == HI) || (state_q == CHK);
    busy       = (state_q != IDLE) && (state_q != DONE);
    done       = (state_q == DONE);
    imem_we    = (state_q == WR);
    imem_addr  = imem_we ? cnt_q : '0;
    imem_wdata = imem_we ? {hi_q, lo_q} : '0;
  end

  assign prog_len   = prog_len_q;
  assign err_len    = err_len_q;
  assign err_chk    = err_chk_q;
  assign err_target = err_target_q;
  assign bad_count  = bad_q;

  // Datapath and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_q          <= '0;
      cnt_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      acc_q        <= '0;
      prog_len_q   <= '0;
      bad_q        <= '0;
      err_len_q    <= 1'b0;
      err_chk_q    <= 1'b0;
      err_target_q <= 1'b0;
    end else if (start_ok) begin
      acc_q        <= '0;
      prog_len_q   <= '0;
      bad_q        <= '0;
      err_len_q    <= 1'b0;
      err_chk_q    <= 1'b0;
      err_target_q <= 1'b0;
    end else begin
      case (state_q)
        LEN: if (xfer) begin
          if (len_bad) begin
            err_len_q <= 1'b1;
          end else begin
            n_q   <= in_data[ADDR_W-1:0];
            cnt_q <= '0;
          end
        end
        LO: if (xfer) begin
          lo_q  <= in_data;
          acc_q <= acc_q ^ in_data;
        end
        HI: if (xfer) begin
          hi_q  <= in_data;
          acc_q <= acc_q ^ in_data;
        end
        WR: begin
          cnt_q <= cnt_inc;
          if (illegal && (bad_q != '1)) bad_q <= bad_q + 1'b1;
          if (out_of_range)             err_target_q <= 1'b1;
        end
        CHK: if (xfer) begin
          err_chk_q  <= (in_data != acc_q);
          prog_len_q <= n_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, busy, done, err_len, err_chk, err_target;
  logic [6:0]  imem_addr, prog_len, bad_count;
  logic [15:0] imem_wdata;

  always #5 clock = ~clock;

  program_loader #(.WORD_W(16), .DEPTH(101), .ADDR_W(7)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .prog_len   (prog_len),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len),
    .err_chk    (err_chk),
    .err_target (err_target),
    .bad_count  (bad_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: records every memory write seen by the DUT port.
  logic [6:0]  got_addr [512];
  logic [15:0] got_data [512];
  logic        got_rdy  [512];
  int          wr_cnt = 0;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      got_addr[wr_cnt % 512] <= imem_addr;
      got_data[wr_cnt % 512] <= imem_wdata;
      got_rdy[wr_cnt % 512]  <= in_ready;
      wr_cnt                 <= wr_cnt + 1;
    end
  end

  typedef struct packed {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];
  int  rd_idx = 0;

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][15:0] w;      // word i uses w[i % 4]
    logic             bad_chk;
    logic [1:0]       gap;
    logic             e_len;
    logic             e_chk;
    logic             e_tgt;
    logic [6:0]       e_bad;
    logic [6:0]       e_plen;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [7:0] len, input logic [15:0] w0, w1, w2, w3,
                              input logic bad_chk, input logic [1:0] gap,
                              input logic e_len, e_chk, e_tgt,
                              input logic [6:0] e_bad, e_plen);
    vec_t v;
    v.len = len; v.w = {w3, w2, w1, w0}; v.bad_chk = bad_chk; v.gap = gap;
    v.e_len = e_len; v.e_chk = e_chk; v.e_tgt = e_tgt; v.e_bad = e_bad; v.e_plen = e_plen;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain(input int w0);
    wr_t e;
    chk("write_count", 32'(wr_cnt - w0), 32'(exp_q.size()));
    rd_idx = w0;
    while (rd_idx < wr_cnt && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_addr", {25'd0, got_addr[rd_idx % 512]}, {25'd0, e.a});
      chk("wr_data", {16'd0, got_data[rd_idx % 512]}, {16'd0, e.d});
      chk("in_ready_in_wr", {31'd0, got_rdy[rd_idx % 512]}, 32'd0);
      rd_idx++;
    end
    rd_idx = wr_cnt;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 50) chk("ready_timeout", 32'(k), 32'd0);
    @(posedge clock); #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) begin @(posedge clock); #1; end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_load(input vec_t v);
    int          n, w0, c0, k;
    logic [7:0]  acc;
    logic [15:0] w;
    w0  = wr_cnt;
    acc = 8'd0;
    pulse_start();
    c0 = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_after_start", {31'd0, done}, 32'd0);
    chk("plen_cleared", {25'd0, prog_len}, 32'd0);
    send_byte(v.len, int'(v.gap));
    if (v.e_len) begin
      chk("done_after_len", {31'd0, done}, 32'd1);
    end else begin
      n = int'(v.len);
      for (int i = 0; i < n; i++) begin
        w = v.w[i % 4];
        send_byte(w[7:0], int'(v.gap));
        send_byte(w[15:8], int'(v.gap));
        acc = acc ^ w[7:0] ^ w[15:8];
        exp_q.push_back('{a: 7'(i), d: w});
      end
      send_byte(v.bad_chk ? ~acc : acc, 0);
      if (v.gap == 2'd0) begin
        chk("done_at_latency", {31'd0, done}, 32'd1);
        chk("load_cycles", 32'(cyc - c0), 32'(3 * n + 2));
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin @(posedge clock); #1; k++; end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("prog_len", {25'd0, prog_len}, {25'd0, v.e_plen});
    chk("err_len", {31'd0, err_len}, {31'd0, v.e_len});
    chk("err_chk", {31'd0, err_chk}, {31'd0, v.e_chk});
    chk("err_target", {31'd0, err_target}, {31'd0, v.e_tgt});
    chk("bad_count", {25'd0, bad_count}, {25'd0, v.e_bad});
    drain(w0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, {25'd0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_prog_len"}, {25'd0, prog_len}, 32'd0);
    chk({tag, "_errs"}, {29'd0, err_len, err_chk, err_target}, 32'd0);
    chk({tag, "_bad_count"}, {25'd0, bad_count}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    //               len    w0       w1       w2       w3       badc gap eL eC eT bad    plen
    vecs[0]  = mk(8'd3,   16'h100A, 16'h1208, 16'h2232, 16'h0000, 0, 0, 0, 0, 0, 7'd0, 7'd3);
    vecs[1]  = mk(8'd3,   16'h100A, 16'h1208, 16'h2232, 16'h0000, 1, 0, 0, 1, 0, 7'd0, 7'd3);
    vecs[2]  = mk(8'd0,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 7'd0, 7'd0);
    vecs[3]  = mk(8'h66,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 7'd0, 7'd0);
    vecs[4]  = mk(8'd2,   16'h002F, 16'hF24E, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 7'd0, 7'd2);
    vecs[5]  = mk(8'd2,   16'h003F, 16'hF24E, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 7'd0, 7'd2);
    vecs[6]  = mk(8'd3,   16'h0003, 16'h0004, 16'h0005, 16'h0000, 0, 0, 0, 0, 0, 7'd3, 7'd3);
    vecs[7]  = mk(8'd3,   16'h100A, 16'h1208, 16'h2232, 16'h0000, 0, 1, 0, 0, 0, 7'd0, 7'd3);
    vecs[8]  = mk(8'd101, 16'h100A, 16'h1208, 16'h2232, 16'h0000, 0, 0, 0, 0, 0, 7'd0, 7'd101);
    vecs[9]  = mk(8'd1,   16'h001F, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 7'd0, 7'd1);
    vecs[10] = mk(8'd1,   16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 7'd0, 7'd1);

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    #12;
    check_idle_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++) do_load(vecs[i]);

    // Reset asserted while the high byte of word 1 is awaited.
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'h0A, 0);
    send_byte(8'h10, 0);
    exp_q.push_back('{a: 7'd0, d: 16'h100A});
    send_byte(8'h08, 0);
    in_valid = 1'b0;
    chk("in_hi_ready", {31'd0, in_ready}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("midload_reset");
    drain(w0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("after_reset");
    do_load(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
